multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle MIPS control unit: an FSM that sequences each instruction over 3–5 states instead of decoding it in a single cycle. It sits between the instruction register (opcode/funct) and the shared-memory multi-cycle datapath. Per state it drives PC, IR, memory, register-file and ALU control. It adds a memory-ready stall handshake, illegal-instruction trapping and a retired-instruction counter.

## Interface
- OPCODE_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- ALU_OP_W, 4, ALU operation code width
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- opcode  in  OPCODE_W  IR opcode field, stable from DECODE to end of instruction
- funct  in  FUNCT_W  IR funct field
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, branch_ne  out  1 each  PC update controls
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write, ir_write  out  1 each
- reg_dst, mem_to_reg, reg_write  out  1 each
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2
- ext_zero  out  1  immediate zero-extended (ori) instead of sign-extended
- alu_op  out  ALU_OP_W  AND 0000, OR 0001, ADD 0010, SUB 0110, DEFAULT 1111
- illegal  out  1  one-cycle pulse on unsupported opcode or funct
- state  out  4  current state encoding, for debug
- instr_count  out  CNT_W  retired instructions

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12.
- Outputs are Moore outputs, except for the mem_ready qualification noted below. Every unlisted output is 0; alu_op is DEFAULT unless stated.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=ADD.
  - Next state by opcode: R-type 000000 → EXEC, or TRAP if funct is not add 100000 / sub 100010 / and 100100 / or 100101.
  - addi 001000 and ori 001101 → I_EXEC.
  - lw 100011 and sw 101011 → MEM_ADDR.
  - beq 000100 → BRANCH.
  - j 000010 → JUMP.
  - Any other opcode → TRAP.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=ADD.
  - Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op decoded from funct. Then R_WB.
- R_WB: reg_write=1, reg_dst=1. Then FETCH.
- I_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - addi: alu_op=ADD. ori: alu_op=OR and ext_zero=1.
  - Then I_WB.
- I_WB: reg_write=1, reg_dst=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- TRAP: illegal=1. Then FETCH; the PC has already advanced, so the illegal instruction is skipped.
- instr_count:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP.
  - A transition from TRAP does not count.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset:
  - While rst_n=0 at a rising edge, the next state is FETCH and instr_count=0.
  - While rst_n is low, all outputs are combinationally forced to 0, and state reads 0.
  - Reset mid-instruction aborts the instruction without counting it.
- Cycle counts with mem_ready held at 1:
  - 3 cycles: beq, j, and illegal instructions.
  - 4 cycles: R-type, addi, ori, sw.
  - 5 cycles: lw.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. mem_read, mem_write and i_or_d stay stable throughout the stall.
- mem_ready is ignored in all other states.
- When the counter is at all-ones and an instruction retires, it reads 0 on the cycle FETCH is entered.

## Configuration
- MC_BNE_EN defined:
  - bne (opcode 000101) → BRANCH.
  - BRANCH then drives the same outputs as beq, plus branch_ne=1.
  - The datapath writes the PC when zero=0.
- MC_BNE_EN undefined:
  - opcode 000101 → TRAP.
  - branch_ne is tied to 0.

## Test plan
- add (opcode 0, funct 100000), mem_ready=1 → states 0,1,6,7,0; alu_op 0010 in EXEC; reg_write=1, reg_dst=1 in R_WB; instr_count 0→1.
- lw, mem_ready low for 2 cycles in MEM_RD → 7 cycles total; mem_read=1, i_or_d=1 throughout MEM_RD; mem_to_reg=1 in MEM_WB.
- ori → ext_zero=1, alu_op=0001 in I_EXEC; beq → pc_write_cond=1, alu_op=0110 in BRANCH; j → pc_write=1, pc_source=10.
- opcode 111111, then R-type with funct 000000 → each gives an illegal pulse for 1 cycle and returns to FETCH; instr_count unchanged.
- rst_n=0 while in MEM_RD → next cycle state=0, all outputs 0, instr_count=0; after release, FETCH with mem_read=1.
- bne (000101): with MC_BNE_EN → BRANCH, branch_ne=1; without → illegal=1.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the instruction register/memory side and the multi-cycle datapath.
// master = control unit (drives the datapath controls), slave = datapath/IR side.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                ext_zero;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
    logic [3:0]          state;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, branch_ne, pc_source, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, ext_zero, alu_op, illegal, state, instr_count
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, pc_source, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, ext_zero, alu_op, illegal, state, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with illegal-op trap and retired-instruction counter; MC_BNE_EN adds bne.
// Latency: 3 cycles (beq/j/trap), 4 (R-type/addi/ori/sw), 5 (lw), plus stall cycles.
// Backpressure: mem_ready=0 holds FETCH, MEM_RD and MEM_WR with memory controls stable.
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC     = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_I_EXEC   = 4'd10,
        ST_I_WB     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
`ifdef MC_BNE_EN
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
`endif

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);

    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4'b0001);
    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0010);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b0110);
    localparam logic [ALU_OP_W-1:0] ALU_DEF = ALU_OP_W'(4'b1111);

    state_t              state_q, next_state;
    logic [CNT_W-1:0]    cnt_q;
    logic                retire;
    logic                funct_ok;
    logic [ALU_OP_W-1:0] r_alu_op;

    logic                pc_write_c, pc_write_cond_c, branch_ne_c, i_or_d_c;
    logic                mem_read_c, mem_write_c, ir_write_c;
    logic                reg_dst_c, mem_to_reg_c, reg_write_c;
    logic                alu_src_a_c, ext_zero_c, illegal_c;
    logic [1:0]          pc_source_c, alu_src_b_c;
    logic [ALU_OP_W-1:0] alu_op_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= next_state;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        funct_ok = 1'b1;
        r_alu_op = ALU_DEF;
        case (bus.funct)
            FN_ADD:  r_alu_op = ALU_ADD;
            FN_SUB:  r_alu_op = ALU_SUB;
            FN_AND:  r_alu_op = ALU_AND;
            FN_OR:   r_alu_op = ALU_OR;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        next_state      = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        branch_ne_c     = 1'b0;
        pc_source_c     = 2'b00;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_dst_c       = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        ext_zero_c      = 1'b0;
        alu_op_c        = ALU_DEF;
        illegal_c       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                alu_op_c    = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b_c = 2'b11;
                alu_op_c    = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:      next_state = funct_ok ? ST_EXEC : ST_TRAP;
                    OP_ADDI,
                    OP_ORI:        next_state = ST_I_EXEC;
                    OP_LW,
                    OP_SW:         next_state = ST_MEM_ADDR;
                    OP_BEQ:        next_state = ST_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:        next_state = ST_BRANCH;
`endif
                    OP_J:          next_state = ST_JUMP;
                    default:       next_state = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = ALU_ADD;
                next_state  = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (bus.mem_ready) next_state = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                next_state   = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (bus.mem_ready) next_state = ST_FETCH;
            end
            ST_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = r_alu_op;
                next_state  = ST_R_WB;
            end
            ST_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                next_state  = ST_FETCH;
            end
            ST_I_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                if (bus.opcode == OP_ORI) begin
                    alu_op_c   = ALU_OR;
                    ext_zero_c = 1'b1;
                end else begin
                    alu_op_c   = ALU_ADD;
                end
                next_state = ST_I_WB;
            end
            ST_I_WB: begin
                reg_write_c = 1'b1;
                next_state  = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = ALU_SUB;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
`ifdef MC_BNE_EN
                branch_ne_c     = (bus.opcode == OP_BNE);
`endif
                next_state      = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                next_state  = ST_FETCH;
            end
            ST_TRAP: begin
                illegal_c  = 1'b1;
                next_state = ST_FETCH;
            end
            default: next_state = ST_FETCH;
        endcase
    end

    // TRAP returning to FETCH is deliberately excluded: a skipped instruction never retires.
    assign retire = (next_state == ST_FETCH) &&
                    (state_q inside {ST_MEM_WB, ST_MEM_WR, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP});

    assign bus.pc_write      = rst_n & pc_write_c;
    assign bus.pc_write_cond = rst_n & pc_write_cond_c;
    assign bus.branch_ne     = rst_n & branch_ne_c;
    assign bus.pc_source     = rst_n ? pc_source_c : 2'b00;
    assign bus.i_or_d        = rst_n & i_or_d_c;
    assign bus.mem_read      = rst_n & mem_read_c;
    assign bus.mem_write     = rst_n & mem_write_c;
    assign bus.ir_write      = rst_n & ir_write_c;
    assign bus.reg_dst       = rst_n & reg_dst_c;
    assign bus.mem_to_reg    = rst_n & mem_to_reg_c;
    assign bus.reg_write     = rst_n & reg_write_c;
    assign bus.alu_src_a     = rst_n & alu_src_a_c;
    assign bus.alu_src_b     = rst_n ? alu_src_b_c : 2'b00;
    assign bus.ext_zero      = rst_n & ext_zero_c;
    assign bus.alu_op        = rst_n ? alu_op_c : '0;
    assign bus.illegal       = rst_n & illegal_c;
    assign bus.state         = rst_n ? state_q : ST_FETCH;
    assign bus.instr_count   = rst_n ? cnt_q : '0;
endmodule
